cur_sel_ctrl: RTL and testbench

CUR_SEL_CTRL -- requirements
Module: cur_sel_ctrl

---
 rtl/cur_sel_ctrl.sv | 119 +++++++++++
 tb/tb_cur_sel_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cur_sel_ctrl.sv
// cur_sel_ctrl: current-DAC code sweep sequencer with per-code dwell, abort and async reset.
// Define CUR_SEL_TRIANGLE_EN to sweep back down to the start code after reaching the end code.
module cur_sel_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [3:0]         code_start,
  input  logic [3:0]         code_end,
  input  logic [DWELL_W-1:0] dwell,
  output logic [3:0]         code,
  output logic               dac_en,
  output logic               busy,
  output logic               step_pulse,
  output logic               done
);
`ifdef CUR_SEL_TRIANGLE_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE, S_RETURN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [3:0] code_q, code_d, end_q, end_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  logic up_q, up_d, step_q, step_d, run_q, run_d, done_q, done_d, fwd, expire;
`ifdef CUR_SEL_TRIANGLE_EN
  logic [3:0] start_q, start_d;
`endif
  assign expire     = cnt_q == '0;
  assign code       = code_q;
  assign dac_en     = run_q;
  assign busy       = run_q;
  assign step_pulse = step_q;
  assign done       = done_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      up_q    <= 1'b0;
      step_q  <= 1'b0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef CUR_SEL_TRIANGLE_EN
      start_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      up_q    <= up_d;
      step_q  <= step_d;
      run_q   <= run_d;
      done_q  <= done_d;
`ifdef CUR_SEL_TRIANGLE_EN
      start_q <= start_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && !abort) state_d = S_DWELL;
      S_DWELL:
        if (abort) state_d = S_IDLE;
        else if (expire && code_q == end_q)
`ifdef CUR_SEL_TRIANGLE_EN
          state_d = (start_q != end_q) ? S_RETURN : S_DONE;
`else
          state_d = S_DONE;
`endif
`ifdef CUR_SEL_TRIANGLE_EN
      S_RETURN:
        if (abort) state_d = S_IDLE;
        else if (expire && code_q == start_q) state_d = S_DONE;
`endif
      default:  state_d = S_IDLE;
    endcase
  end
  // Entering RETURN steps immediately so the peak code is not held twice.
  always_comb begin
    run_d = state_d == S_DWELL;
    fwd   = up_q;
`ifdef CUR_SEL_TRIANGLE_EN
    run_d   = run_d || state_d == S_RETURN;
    fwd     = (state_d == S_DWELL) ? up_q : !up_q;
    start_d = (state_q == S_IDLE && run_d) ? code_start : start_q;
`endif
    code_d  = code_q;
    cnt_d   = cnt_q;
    end_d   = end_q;
    dwell_d = dwell_q;
    up_d    = up_q;
    step_d  = 1'b0;
    done_d  = state_d == S_DONE;
    if (state_q == S_IDLE && run_d) begin
      code_d  = code_start;
      end_d   = code_end;
      dwell_d = dwell;
      cnt_d   = dwell;
      up_d    = code_end >= code_start;
    end else if (run_d && expire) begin
      code_d = fwd ? code_q + 4'd1 : code_q - 4'd1;
      cnt_d  = dwell_q;
      step_d = 1'b1;
    end else if (run_d) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      code_d = '0;
      cnt_d  = '0;
    end
  end
endmodule

// File: tb/tb_cur_sel_ctrl.sv
// tb_cur_sel_ctrl: randomized and directed sweeps of cur_sel_ctrl against a code-sequence model.
module tb_cur_sel_ctrl;
  localparam int DW = 8;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [3:0] code_start = '0, code_end = '0;
  logic [DW-1:0] dwell = '0;
  logic [3:0] code;
  logic dac_en, busy, step_pulse, done;
  int vectors = 0, miscompares = 0;

  cur_sel_ctrl #(.DWELL_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .code_start(code_start), .code_end(code_end), .dwell(dwell),
    .code(code), .dac_en(dac_en), .busy(busy), .step_pulse(step_pulse), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_done);
    chk({tag, ".code"}, code, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".dac_en"}, dac_en, 0);
    chk({tag, ".step"}, step_pulse, 0);
    chk({tag, ".done"}, done, exp_done);
  endtask

  // Model: list of visited codes, each repeated dwell+1 times; done follows the last entry.
  task automatic sweep(input int s, input int e, input int dw, input int abort_at);
    int pts[$];
    int seq[$];
    int sz;
    if (e >= s) for (int c = s; c <= e; c++) pts.push_back(c);
    else        for (int c = s; c >= e; c--) pts.push_back(c);
`ifdef CUR_SEL_TRIANGLE_EN
    sz = pts.size();
    if (s != e) for (int i = sz - 2; i >= 0; i--) pts.push_back(pts[i]);
`endif
    foreach (pts[i]) for (int r = 0; r <= dw; r++) seq.push_back(pts[i]);
    @(negedge clk);
    start = 1'b1; abort = 1'b0;
    code_start = 4'(s); code_end = 4'(e); dwell = DW'(dw);
    @(posedge clk); #1;
    start = 1'b0;
    code_start = 4'($urandom); code_end = 4'($urandom); dwell = DW'($urandom);
    for (int k = 0; k < seq.size(); k++) begin
      chk("sweep.code", code, seq[k]);
      chk("sweep.busy", busy, 1);
      chk("sweep.dac_en", dac_en, 1);
      chk("sweep.step", step_pulse, (k > 0) ? (seq[k] != seq[k-1]) : 1'b0);
      chk("sweep.done", done, 0);
      start = (k == 1);
      abort = (k + 1 == abort_at);
      @(posedge clk); #1;
      start = 1'b0;
      if (abort) begin
        abort = 1'b0;
        chk_idle("abort", 1'b0);
        @(posedge clk); #1;
        chk_idle("post_abort", 1'b0);
        return;
      end
    end
    chk_idle("done_cycle", 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_idle("after_done", 1'b0);
  endtask

  initial begin
    int s, e;
    repeat (2) @(posedge clk);
    #1;
    chk_idle("reset_state", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sweep(2, 5, 1, -1);
    sweep(12, 9, 0, -1);
    sweep(7, 7, 3, -1);
    sweep(0, 15, 1, 3);
    @(negedge clk);
    start = 1'b1; abort = 1'b1; code_start = 4'd3; code_end = 4'd8; dwell = '0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort", 1'b0);
`ifdef CUR_SEL_TRIANGLE_EN
    sweep(0, 3, 0, -1);
`endif
    @(negedge clk);
    start = 1'b1; code_start = 4'd0; code_end = 4'd15; dwell = DW'(2);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    chk("pre_reset.busy", busy, 1);
    reset = 1'b1;
    #1;
    chk_idle("async_reset", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    sweep(4, 6, 0, -1);
    for (int t = 0; t < 14; t++) begin
      s = int'($urandom_range(0, 15));
      e = int'($urandom_range(0, 15));
      sweep(s, e, int'($urandom_range(0, 3)), (t % 4 == 3) ? int'($urandom_range(1, 4)) : -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
